ps2_scan_decoder: RTL and testbench
===================================

PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 Parameter EV_DEPTH, default 8, event FIFO depth; power of two, 2..64.
REQ-002 clk  in  1  single system clock; all state on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 sc_data  in  8  head scan-code byte from the PS/2 receiver FIFO.
REQ-005 sc_valid  in  1  receiver FIFO non-empty; sc_data is valid.
REQ-006 sc_overflow  in  1  receiver FIFO overflow pulse.
REQ-007 sc_pop  out  1  combinational; consume head byte this cycle; drives the receiver's next-data input (active-high here, inverted at integration).
REQ-008 ev_valid  out  1  event FIFO non-empty.
REQ-009 ev_code  out  8  head event scan code (prefixes stripped).
REQ-010 ev_ext  out  1  head event carried the E0 prefix.
REQ-011 ev_brk  out  1  head event is a release (F0).
REQ-012 ev_mods  out  4  {caps, alt, ctrl, shift} after applying the head event.
REQ-013 ev_pop  in  1  consumer pops the head event.
REQ-014 ovf  out  1  sticky error flag; set on upstream overflow.
REQ-015 ovf_clr  in  1  clears ovf.

Function
REQ-016 sc_pop = sc_valid & ~ev_full & rst; one byte consumed per cycle maximum.
REQ-017 Decode FSM states: IDLE, E0, F0, E0F0, SKIP; state advances only on a consumed byte.
REQ-018 IDLE: E0->E0; F0->F0; E1->SKIP with skip counter=7; other code->emit {code, ext0, brk0}.
REQ-019 E0: F0->E0F0; code->emit {code, ext1, brk0}, ->IDLE.
REQ-020 F0: code->emit {code, ext0, brk1}, ->IDLE; E0F0: code->emit {code, ext1, brk1}, ->IDLE.
REQ-021 SKIP: decrement per consumed byte; at 0 ->IDLE; no events (Pause sequence discarded).
REQ-022 Bytes 00, AA, FA, FE, FF in any state: discarded, no event, FSM ->IDLE, skip counter cleared.
REQ-023 Ext code 12 or 59 (fake shift, make or break): discarded, no event, ->IDLE.
REQ-024 Modifier tracking, internal L/R bits: 12 lshift, 59 rshift, 14 lctrl, E0 14 rctrl, 11 lalt, E0 11 ralt; make sets, break clears.
REQ-025 Non-ext 58 make toggles caps; 58 break no effect on caps.
REQ-026 ev_mods = {caps, lalt|ralt, lctrl|rctrl, lshift|rshift}, computed with this event applied, captured at push.
REQ-027 Latency: final byte consumed in cycle T -> event pushed at edge ending T; ev_valid high in T+1.
REQ-028 Event FIFO: ev_pop with ev_valid pops head at edge; ev_pop when empty ignored.
REQ-029 Simultaneous push and pop: both occur, occupancy unchanged; pop on full frees slot, sc_pop re-asserts next cycle.
REQ-030 Full: sc_pop low; no byte dropped, no event overwritten; pointers wrap modulo EV_DEPTH.
REQ-031 sc_overflow high: FSM ->IDLE, skip counter cleared, ovf<=1; byte in same cycle discarded; modifiers and event FIFO kept.
REQ-032 ovf_clr clears ovf; ovf_clr and sc_overflow together: ovf=1 (set wins).

Reset
REQ-033 rst low: FSM IDLE, skip counter 0, all modifier bits 0, caps 0, FIFO pointers/count 0, ovf 0.
REQ-034 During reset outputs: sc_pop 0, ev_valid 0, ev_code/ev_ext/ev_brk/ev_mods 0.
REQ-035 Reset mid-sequence discards partial prefix state; first byte after release decoded from IDLE.

Structure
REQ-036 Package ps2_pkg: FSM state enum, scan-code constants (E0, E1, F0, 12, 59, 14, 11, 58, discard set), kbd_event_t struct {mods, brk, ext, code}.
REQ-037 One sub-module kbd_event_fifo: synchronous FIFO of kbd_event_t, parameter EV_DEPTH, outputs full/empty.

Verification
REQ-038 Byte 1C, ev_pop 0 -> one event code 1C ext0 brk0 mods 0000, ev_valid in next cycle.
REQ-039 12,1C,F0,1C,F0,12 -> events 12/mods 0001; 1C/0001; 1C brk/0001; 12 brk/0000.
REQ-040 E0,F0,74 -> code 74 ext1 brk1; E0,12,E0,7C -> single event 7C ext1 only; 58,F0,58 -> 58 mods 1000, 58 brk mods 1000.
REQ-041 E1,14,77,E1,F0,14,F0,77 then 1C -> only event 1C ext0.
REQ-042 EV_DEPTH=8, 9 code bytes, ev_pop 0 -> 8 events, sc_pop low with 9th pending; one ev_pop -> 9th accepted next cycle; order preserved.
REQ-043 E0 then sc_overflow pulse then 1C -> event 1C ext0, ovf 1; ovf_clr -> ovf 0; rst low after F0 then 1C -> make event.

Source files
------------

// File: rtl/ps2_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg -- shared types, scan-code constants and helpers for the PS/2
//            scan-code decoder.                               Rev 1.0
// ============================================================================
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_E0   = 3'd1,
    ST_F0   = 3'd2,
    ST_E0F0 = 3'd3,
    ST_SKIP = 3'd4
  } dec_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Keyboard status / error bytes that never carry key information.
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // Bytes following E1 in the Pause make sequence.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef struct packed {
    logic [3:0] mods;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  typedef struct packed {
    logic caps;
    logic lalt;
    logic ralt;
    logic lctrl;
    logic rctrl;
    logic lshift;
    logic rshift;
  } mod_state_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_BAT) || (b == SC_ACK) ||
           (b == SC_RESEND) || (b == SC_ERR1);
  endfunction

  function automatic logic [3:0] pack_mods(input mod_state_t m);
    return {m.caps, m.lalt | m.ralt, m.lctrl | m.rctrl, m.lshift | m.rshift};
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_event_fifo.sv
`default_nettype none
// ============================================================================
// kbd_event_fifo -- synchronous FIFO of decoded keyboard events.
//                                                             Rev 1.0
// ============================================================================
module kbd_event_fifo
  import ps2_pkg::*;
#(
  parameter int EV_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  kbd_event_t push_data,
  input  logic       pop,
  output kbd_event_t head,
  output logic       full,
  output logic       empty
);

  localparam int             PTR_W    = (EV_DEPTH > 1) ? $clog2(EV_DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(EV_DEPTH);

  kbd_event_t       mem_q [EV_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
// ps2_scan_decoder -- turns PS/2 set-2 scan bytes into make/break events with
//                     modifier state, buffered in an event FIFO.  Rev 1.0
// ============================================================================
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int EV_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sc_data,
  input  logic       sc_valid,
  input  logic       sc_overflow,
  output logic       sc_pop,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic [3:0] ev_mods,
  input  logic       ev_pop,
  output logic       ovf,
  input  logic       ovf_clr
);

  dec_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  mod_state_t mods_q, mods_d;
  logic       ovf_q, ovf_d;

  logic       ev_full;
  logic       ev_empty;
  logic       take;
  logic       is_prefix;
  logic       emit;
  logic       emit_ext;
  logic       emit_brk;
  kbd_event_t ev_new;
  kbd_event_t ev_head;

  assign sc_pop    = sc_valid & ~ev_full & rst;
  // A byte popped during an overflow pulse is thrown away undecoded.
  assign take      = sc_pop & ~sc_overflow & ~is_discard(sc_data);
  assign is_prefix = (sc_data == SC_EXT) | (sc_data == SC_PAUSE) | (sc_data == SC_BRK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (sc_overflow || (sc_pop && is_discard(sc_data))) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end else if (take) begin
      if (state_q == ST_SKIP) begin
        skip_d = skip_q - 3'd1;
        if (skip_q <= 3'd1) begin
          state_d = ST_IDLE;
          skip_d  = '0;
        end
      end else if (sc_data == SC_EXT) begin
        state_d = ST_E0;
      end else if (sc_data == SC_PAUSE) begin
        state_d = ST_SKIP;
        skip_d  = PAUSE_TAIL;
      end else if (sc_data == SC_BRK) begin
        state_d = ((state_q == ST_E0) || (state_q == ST_E0F0)) ? ST_E0F0 : ST_F0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    emit_ext = (state_q == ST_E0) || (state_q == ST_E0F0);
    emit_brk = (state_q == ST_F0) || (state_q == ST_E0F0);
    // Extended 12/59 are the synthetic shifts around navigation keys.
    emit     = take && !is_prefix && (state_q != ST_SKIP) &&
               !(emit_ext && ((sc_data == SC_LSHIFT) || (sc_data == SC_RSHIFT)));

    mods_d = mods_q;
    if (emit) begin
      if (!emit_ext) begin
        case (sc_data)
          SC_LSHIFT: mods_d.lshift = !emit_brk;
          SC_RSHIFT: mods_d.rshift = !emit_brk;
          SC_CTRL:   mods_d.lctrl  = !emit_brk;
          SC_ALT:    mods_d.lalt   = !emit_brk;
          SC_CAPS:   if (!emit_brk) mods_d.caps = !mods_q.caps;
          default:   mods_d = mods_q;
        endcase
      end else begin
        case (sc_data)
          SC_CTRL: mods_d.rctrl = !emit_brk;
          SC_ALT:  mods_d.ralt  = !emit_brk;
          default: mods_d = mods_q;
        endcase
      end
    end

    ev_new.mods = pack_mods(mods_d);
    ev_new.brk  = emit_brk;
    ev_new.ext  = emit_ext;
    ev_new.code = sc_data;

    if (sc_overflow)  ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mods_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      mods_q <= mods_d;
      ovf_q  <= ovf_d;
    end
  end

  kbd_event_fifo #(
    .EV_DEPTH (EV_DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (emit),
    .push_data (ev_new),
    .pop       (ev_pop),
    .head      (ev_head),
    .full      (ev_full),
    .empty     (ev_empty)
  );

  assign ev_valid = ~ev_empty;
  assign ev_code  = ev_valid ? ev_head.code : 8'h00;
  assign ev_ext   = ev_valid & ev_head.ext;
  assign ev_brk   = ev_valid & ev_head.brk;
  assign ev_mods  = ev_valid ? ev_head.mods : 4'h0;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
// tb_ps2_scan_decoder -- scoreboard bench with a key-state reference model.
//                                                             Rev 1.0
// ============================================================================
module tb_ps2_scan_decoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sc_data;
  logic       sc_valid;
  logic       sc_overflow;
  logic       sc_pop;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic [3:0] ev_mods;
  logic       ev_pop;
  logic       ovf;
  logic       ovf_clr;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.EV_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .sc_data     (sc_data),
    .sc_valid    (sc_valid),
    .sc_overflow (sc_overflow),
    .sc_pop      (sc_pop),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_brk      (ev_brk),
    .ev_mods     (ev_mods),
    .ev_pop      (ev_pop),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  logic [7:0]  rx_q [$];
  logic [13:0] exp_q [$];
  logic [7:0]  seq [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          auto_pop = 1'b0;
  int          pop_pct  = 100;
  bit          pop_pend = 1'b0;
  logic [13:0] mon_got, mon_want;

  // Reference model: pending prefix flags plus the set of keys held down.
  bit m_ext, m_brk, m_caps;
  int m_skip;
  bit held [512];

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_caps = 0; m_skip = 0;
    foreach (held[i]) held[i] = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [3:0] mods;
    if (b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0; m_skip = 0;
      return;
    end
    if (m_skip > 0) begin m_skip--; return; end
    if (b == 8'hE0) begin m_ext = 1; m_brk = 0; return; end
    if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (m_ext && (b == 8'h12 || b == 8'h59)) begin m_ext = 0; m_brk = 0; return; end
    held[{m_ext, b}] = !m_brk;
    if (!m_ext && !m_brk && b == 8'h58) m_caps = !m_caps;
    mods = {m_caps, held[9'h011] | held[9'h111], held[9'h014] | held[9'h114],
            held[9'h012] | held[9'h059]};
    exp_q.push_back({mods, m_brk, m_ext, b});
    m_ext = 0; m_brk = 0;
  endfunction

  // Receiver FIFO stand-in: pops when the DUT consumed the head.
  always @(negedge clk) pop_pend = sc_pop;
  always @(posedge clk) begin
    if (pop_pend && rx_q.size() != 0) void'(rx_q.pop_front());
    #1;
    sc_valid = (rx_q.size() != 0);
    if (sc_valid) sc_data = rx_q[0];
    else          sc_data = 8'h00;
  end

  always @(posedge clk) begin
    #1;
    if (auto_pop) ev_pop = ($urandom_range(0, 99) < pop_pct);
  end

  always @(negedge clk) begin
    if (rst && ev_valid && ev_pop) begin
      mon_got = {ev_mods, ev_brk, ev_ext, ev_code};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL event: got mods=%b brk=%b ext=%b code=%h but none expected",
                 ev_mods, ev_brk, ev_ext, ev_code);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got == mon_want) n_pass++;
        else $display("FAIL event: got mods=%b brk=%b ext=%b code=%h, want mods=%b brk=%b ext=%b code=%h",
                      ev_mods, ev_brk, ev_ext, ev_code,
                      mon_want[13:10], mon_want[9], mon_want[8], mon_want[7:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    model_byte(b);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send(seq[i]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    tick(3);
    @(negedge clk);
    chk({tag, "_drained"}, 32'(rx_q.size() + exp_q.size()), 32'd0);
    chk({tag, "_no_extra"}, 32'(ev_valid), 32'd0);
    tick(1);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 19))
      0, 1, 2: return 8'hE0;
      3, 4, 5: return 8'hF0;
      6:       return 8'hE1;
      7: case ($urandom_range(0, 4))
           0: return 8'h00;
           1: return 8'hAA;
           2: return 8'hFA;
           3: return 8'hFE;
           default: return 8'hFF;
         endcase
      8, 9, 10, 11: case ($urandom_range(0, 4))
           0: return 8'h12;
           1: return 8'h59;
           2: return 8'h14;
           3: return 8'h11;
           default: return 8'h58;
         endcase
      default: return 8'($urandom_range(1, 127));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; sc_valid = 1'b0; sc_data = 8'h00; sc_overflow = 1'b0;
    ovf_clr = 1'b0; ev_pop = 1'b0;
    model_reset();

    // Reset state with a byte already waiting upstream.
    send(8'h1C);
    tick(3);
    @(negedge clk);
    chk("rst_sc_pop", 32'(sc_pop), 0);
    chk("rst_ev_valid", 32'(ev_valid), 0);
    chk("rst_ev_code", 32'(ev_code), 0);
    chk("rst_ev_ext_brk", 32'({ev_ext, ev_brk}), 0);
    chk("rst_ev_mods", 32'(ev_mods), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // Single-cycle latency from consumption to ev_valid.
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk);
    chk("lat_sc_pop", 32'(sc_pop), 1);
    chk("lat_valid_before", 32'(ev_valid), 0);
    @(negedge clk);
    chk("lat_valid_after", 32'(ev_valid), 1);
    tick(1);
    auto_pop = 1'b1; pop_pct = 100;
    wait_idle("single");

    seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}; send_seq(); wait_idle("shift");
    seq = '{8'hE0, 8'hF0, 8'h74};                     send_seq(); wait_idle("ext_brk");
    seq = '{8'hE0, 8'h12, 8'hE0, 8'h7C};              send_seq(); wait_idle("fake_shift");
    seq = '{8'h58, 8'hF0, 8'h58};                     send_seq(); wait_idle("caps");
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    send_seq(); wait_idle("pause");
    seq = '{8'hE0, 8'hFA, 8'h1C, 8'hE0, 8'h14, 8'hE0, 8'h11, 8'h2A, 8'hE0, 8'hF0, 8'h14};
    send_seq(); wait_idle("discard_rmods");

    // Backpressure: fill the event FIFO and hold one byte upstream.
    auto_pop = 1'b0; ev_pop = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send(8'(8'h20 + i));
    tick(DEPTH + 6);
    @(negedge clk);
    chk("full_ev_valid", 32'(ev_valid), 1);
    chk("full_sc_pop", 32'(sc_pop), 0);
    chk("full_pending", 32'(rx_q.size()), 1);
    tick(1);
    ev_pop = 1'b1;
    tick(1);
    ev_pop = 1'b0;
    @(negedge clk);
    chk("full_resume_pop", 32'(sc_pop), 1);
    tick(1);
    auto_pop = 1'b1;
    wait_idle("full");

    // Overflow flag handling.
    send(8'hE0); wait_idle("ovf_pre");
    sc_overflow = 1'b1; tick(1); sc_overflow = 1'b0;
    m_ext = 0; m_brk = 0; m_skip = 0;
    @(negedge clk); chk("ovf_set", 32'(ovf), 1);
    send(8'h1C); wait_idle("ovf_post");
    chk("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    @(negedge clk); chk("ovf_clear", 32'(ovf), 0);
    tick(1);
    sc_overflow = 1'b1; ovf_clr = 1'b1; tick(1); sc_overflow = 1'b0; ovf_clr = 1'b0;
    @(negedge clk); chk("ovf_set_wins", 32'(ovf), 1);
    tick(1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;

    // Reset mid-sequence with a modifier held.
    seq = '{8'h12, 8'hF0}; send_seq(); wait_idle("rst_pre");
    rst = 1'b0; model_reset();
    tick(2);
    rst = 1'b1;
    send(8'h1C); wait_idle("rst_post");

    // Randomised traffic, first light then heavy backpressure.
    pop_pct = 60;
    for (int i = 0; i < 400; i++) begin
      send(rand_byte());
      if ($urandom_range(0, 3) == 0) tick(1);
    end
    wait_idle("rand_a");
    pop_pct = 15;
    for (int i = 0; i < 300; i++) send(rand_byte());
    wait_idle("rand_b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
